decimator_10x: RTL and testbench
================================

Name: decimator_10x

Overview:
- Inverse of the 10x interpolation path: takes a 480 kHz sample stream, qualified by a strobe, and produces one 48 kHz sample per block of RATIO input samples.
- Each output is the block average: sum of RATIO samples divided by RATIO, computed by a sequential restoring divider.
- Sits between a 480 kHz source (demodulated PDM/ADC front end) and 48 kHz consumers.
- A sync pulse aligns block boundaries to the system 48 kHz pulse.

Parameters:
- INPUT_WIDTH, 8, width of sample_in and sample_out (unsigned).
- RATIO, 10, decimation factor; legal range 2..16.
- SUM_W, INPUT_WIDTH+4, accumulator/dividend width; must hold RATIO*(2^INPUT_WIDTH-1)+RATIO/2.

Ports:
- clk  in  1  system clock (96 MHz nominal).
- reset_n  in  1  asynchronous active-low reset.
- clk_en_10x  in  1  input strobe; sample_in is valid in any cycle where this is high.
- sync  in  1  one-cycle block-alignment pulse (48 kHz).
- sample_in  in  INPUT_WIDTH  input sample.
- clear_overrun  in  1  synchronous clear of the overrun flag.
- sample_out  out  INPUT_WIDTH  last decimated sample; held until the next result.
- out_valid  out  1  one-cycle pulse when sample_out updates.
- busy  out  1  divider running.
- overrun  out  1  sticky flag: a completed block was dropped.

Behaviour:
- Reset (reset_n low, asynchronous): accumulator=0, phase=0, divider idle, sample_out=0, out_valid=0, busy=0, overrun=0.
  - Reset mid-division aborts the division. No out_valid is produced for that block.
- Accumulate:
  - On a cycle with clk_en_10x high: acc += sample_in; phase increments.
  - When phase == RATIO-1 and a strobe arrives, the block is complete:
    - dividend = acc + sample_in (+ RATIO/2 when rounding is enabled) is handed to the divider.
    - acc and phase clear to 0 in the same cycle.
  - No strobe: no state change.
- sync:
  - acc=0 and phase=0.
  - sync + strobe in the same cycle: that sample becomes sample 0 of the new block (acc=sample_in, phase=1). The partial block is discarded and produces no output.
  - sync does not affect a division in progress.
- Divider FSM: IDLE -> DIV -> DONE -> IDLE.
  - IDLE -> DIV: on block complete; latch dividend; busy=1.
  - DIV: one restoring quotient bit per cycle, MSB first; exactly SUM_W cycles.
  - DONE: sample_out = quotient[INPUT_WIDTH-1:0]; out_valid=1 for one cycle; busy=0 on the next cycle.
  - The quotient never exceeds 2^INPUT_WIDTH-1, so no saturation is needed.
- Latency: if block completion is in cycle k, out_valid is high in cycle k+SUM_W+1 (k+13 at defaults).
- Overrun:
  - A block completing while busy=1 is dropped, and overrun is set. Accumulation continues normally.
  - A block completing in the DONE cycle is accepted: the divider restarts the next cycle.
  - clear_overrun clears the flag. If a drop and clear_overrun occur in the same cycle, set wins.
- Arithmetic: all unsigned. Accumulator width is SUM_W, with no wrap for legal parameters.

Optional Feature:
- Macro: DECIM_ROUND_EN.
- Defined: RATIO/2 is added to the dividend, giving round-half-up.
- Undefined: plain sum, giving a truncating (floor) average.
- Latency is identical in both builds.

Test Plan:
- Constant input: 10 strobes of sample_in=100, spaced 200 clk apart -> one out_valid, sample_out=100, exactly 13 cycles after the 10th strobe.
- Ramp 0..9: sum 45 -> sample_out=5 with DECIM_ROUND_EN, 4 without. Full-scale 255 x10 -> 255 in both builds.
- Sync alignment: 4 strobes of 200, then sync together with a strobe of 50, then 9 more strobes of 50 -> exactly one out_valid, value 50. No output for the partial block.
- Overrun: clk_en_10x held high for 20 cycles with sample 10 -> first block yields 10; second block completes while busy -> dropped; overrun=1 until clear_overrun pulses, then 0.
- Reset mid-division: assert reset_n low 5 cycles after block completion -> busy, out_valid, sample_out and overrun are 0 immediately. No out_valid follows; the next full block after release yields the correct average.
- Back-to-back boundary: block completing in the DONE cycle -> accepted, second out_valid exactly 14 cycles after the first, overrun stays 0.

Source files
------------

// File: rtl/decimator_10x.sv
// decimator_10x: averages each block of RATIO strobed samples through a sequential
// restoring divider. Define DECIM_ROUND_EN for round-half-up instead of floor.
module decimator_10x #(
  parameter int INPUT_WIDTH = 8,
  parameter int RATIO       = 10,
  parameter int SUM_W       = INPUT_WIDTH + 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clk_en_10x,
  input  logic                   sync,
  input  logic [INPUT_WIDTH-1:0] sample_in,
  input  logic                   clear_overrun,
  output logic [INPUT_WIDTH-1:0] sample_out,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   overrun,
  output logic [1:0]             dbg_state
);

  // Handshake: a sample is consumed on every cycle clk_en_10x is high (no back-pressure);
  // out_valid is a one-cycle pulse and sample_out holds its value until the next pulse.

  localparam int PH_W       = $clog2(RATIO);
  localparam int RW         = $clog2(RATIO);
  localparam int CNT_W      = $clog2(SUM_W);
  localparam int LAST_PH_I  = RATIO - 1;
  localparam int LAST_CNT_I = SUM_W - 1;
  localparam logic [PH_W-1:0]  LAST_PH  = LAST_PH_I[PH_W-1:0];
  localparam logic [CNT_W-1:0] LAST_CNT = LAST_CNT_I[CNT_W-1:0];
  localparam logic [RW+1:0]    DIVISOR  = {1'b0, RATIO[RW:0]};

`ifdef DECIM_ROUND_EN
  localparam int HALF_I = RATIO / 2;
`else
  localparam int HALF_I = 0;
`endif
  localparam logic [SUM_W-1:0] ROUND_ADD = HALF_I[SUM_W-1:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [SUM_W-1:0] acc_q;
  logic [PH_W-1:0]  phase_q;
  logic [SUM_W-1:0] sample_ext;
  logic [SUM_W-1:0] dividend;
  logic             block_done;

  state_t           state_q, state_d;
  logic [SUM_W-1:0] dvd_q, dvd_d;
  logic [SUM_W-1:0] pend_dvd_q;
  logic             pend_q;
  logic [RW-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q;
  logic             start, drop, defer;
  logic [RW:0]      trial;
  logic [RW+1:0]    diff;
  logic             fits;

  assign sample_ext = {{(SUM_W-INPUT_WIDTH){1'b0}}, sample_in};
  assign block_done = clk_en_10x && !sync && (phase_q == LAST_PH);
  assign dividend   = acc_q + sample_ext + ROUND_ADD;

  // sync discards the partial block; a coincident strobe opens the new one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q   <= '0;
      phase_q <= '0;
    end else if (sync) begin
      if (clk_en_10x) begin
        acc_q   <= sample_ext;
        phase_q <= PH_W'(1);
      end else begin
        acc_q   <= '0;
        phase_q <= '0;
      end
    end else if (clk_en_10x) begin
      if (block_done) begin
        acc_q   <= '0;
        phase_q <= '0;
      end else begin
        acc_q   <= acc_q + sample_ext;
        phase_q <= phase_q + PH_W'(1);
      end
    end
  end

  // A block finishing in DONE is parked for one cycle, then started from IDLE.
  assign start = (state_q == S_IDLE) && (pend_q || block_done);
  assign drop  = (state_q == S_DIV) && block_done;
  assign defer = (state_q == S_DONE) && block_done;

  // Partial remainder stays below RATIO, so the trial value stays below 2*RATIO
  // and a non-negative difference never reaches bit RW.
  assign trial = {rem_q, dvd_q[SUM_W-1]};
  assign diff  = {1'b0, trial} - DIVISOR;
  assign fits  = (diff[RW+1:RW] == 2'b00);

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DIV;
          dvd_d   = pend_q ? pend_dvd_q : dividend;
          rem_d   = '0;
        end
      end
      S_DIV: begin
        // dividend bits leave at the top while quotient bits enter at the bottom
        dvd_d = {dvd_q[SUM_W-2:0], fits};
        rem_d = fits ? diff[RW-1:0] : trial[RW-1:0];
        if (cnt_q == LAST_CNT) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      dvd_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_dvd_q <= '0;
      sample_out <= '0;
      overrun    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      cnt_q   <= (state_q == S_DIV) ? cnt_q + CNT_W'(1) : '0;
      if (defer) begin
        pend_q     <= 1'b1;
        pend_dvd_q <= dividend;
      end else if (start) begin
        pend_q <= 1'b0;
      end
      if ((state_q == S_DIV) && (cnt_q == LAST_CNT))
        sample_out <= dvd_d[INPUT_WIDTH-1:0];
      if (drop)
        overrun <= 1'b1;
      else if (clear_overrun)
        overrun <= 1'b0;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_decimator_10x.sv
// Bench for decimator_10x: block-average reference model with per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_decimator_10x;

  localparam int IW    = 8;
  localparam int RATIO = 10;
  localparam int SUM_W = 12;
  localparam int LAT   = SUM_W + 1;
`ifdef DECIM_ROUND_EN
  localparam int RND      = RATIO / 2;
  localparam int RAMP_EXP = 5;
`else
  localparam int RND      = 0;
  localparam int RAMP_EXP = 4;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clk_en_10x = 1'b0;
  logic          sync = 1'b0;
  logic          clear_overrun = 1'b0;
  logic [IW-1:0] sample_in = '0;
  logic [IW-1:0] sample_out;
  logic          out_valid;
  logic          busy;
  logic          overrun;
  logic [1:0]    dbg_state;

  decimator_10x dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clk_en_10x    (clk_en_10x),
    .sync          (sync),
    .sample_in     (sample_in),
    .clear_overrun (clear_overrun),
    .sample_out    (sample_out),
    .out_valid     (out_valid),
    .busy          (busy),
    .overrun       (overrun),
    .dbg_state     (dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  int            blk[$];
  logic [IW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  bit            busy_map[int];
  int            done_cycle = -100;
  logic [IW-1:0] exp_sample = '0;
  logic          exp_ovr = 1'b0;
  logic          ovr_next = 1'b0;
  logic          exp_v;

  int            n_checks = 0;
  int            n_err = 0;
  int            n_out = 0;
  int            last_out_cyc = -1;
  int            prev_out_cyc = -1;
  logic [IW-1:0] last_out_val = '0;
  bit            chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    blk.delete();
    exp_q.delete();
    exp_cyc_q.delete();
    busy_map.delete();
    done_cycle = -100;
    exp_sample = '0;
    exp_ovr    = 1'b0;
    ovr_next   = 1'b0;
  endtask

  // One input cycle: average of each complete block, scheduled LAT cycles later,
  // one extra cycle if it lands on the result cycle, dropped if the divider is mid-run.
  task automatic model_step(input logic en, input logic sy, input logic [IW-1:0] s, input logic clr);
    int   sum;
    int   avg;
    int   out_c;
    logic drop;
    drop = 1'b0;
    if (sy) begin
      blk.delete();
      if (en) blk.push_back(int'(s));
    end else if (en) begin
      blk.push_back(int'(s));
      if (blk.size() == RATIO) begin
        sum = 0;
        foreach (blk[i]) sum += blk[i];
        avg = (sum + RND) / RATIO;
        blk.delete();
        if (cyc >= done_cycle - (LAT - 1) && cyc < done_cycle) begin
          drop = 1'b1;
        end else begin
          out_c = (cyc == done_cycle) ? cyc + LAT + 1 : cyc + LAT;
          exp_q.push_back(avg[IW-1:0]);
          exp_cyc_q.push_back(out_c);
          for (int i = out_c - (LAT - 1); i <= out_c; i++) busy_map[i] = 1'b1;
          done_cycle = out_c;
        end
      end
    end
    ovr_next = drop ? 1'b1 : (clr ? 1'b0 : exp_ovr);
  endtask

  // driver tasks
  task automatic tick(input logic en, input logic sy, input logic [IW-1:0] s, input logic clr);
    clk_en_10x    = en;
    sync          = sy;
    sample_in     = s;
    clear_overrun = clr;
    model_step(en, sy, s, clr);
    @(posedge clk);
    exp_ovr = ovr_next;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic strobes(input int n, input logic [IW-1:0] v);
    repeat (n) tick(1'b1, 1'b0, v, 1'b0);
  endtask

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      exp_v = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
      if (exp_v) begin
        exp_sample = exp_q.pop_front();
        void'(exp_cyc_q.pop_front());
      end
      check("out_valid", 32'(out_valid), 32'(exp_v));
      check("sample_out", 32'(sample_out), 32'(exp_sample));
      check("busy", 32'(busy), 32'(busy_map.exists(cyc)));
      check("overrun", 32'(overrun), 32'(exp_ovr));
      if (out_valid === 1'b1) begin
        n_out++;
        prev_out_cyc = last_out_cyc;
        last_out_cyc = cyc;
        last_out_val = sample_out;
      end
    end
  end

  int n0;
  int k;

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sample_out", 32'(sample_out), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    idle(5);

    // constant 100, strobes 200 cycles apart
    n0 = n_out;
    k  = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) k = cyc;
      tick(1'b1, 1'b0, 8'd100, 1'b0);
      if (i < 9) idle(199);
    end
    idle(20);
    check("const_count", 32'(n_out - n0), 32'd1);
    check("const_value", 32'(last_out_val), 32'd100);
    check("const_latency", 32'(last_out_cyc - k), 32'd13);

    // ramp 0..9
    n0 = n_out;
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 8'(i), 1'b0);
    idle(20);
    check("ramp_count", 32'(n_out - n0), 32'd1);
    check("ramp_value", 32'(last_out_val), 32'(RAMP_EXP));

    // full scale
    n0 = n_out;
    strobes(10, 8'd255);
    idle(20);
    check("full_count", 32'(n_out - n0), 32'd1);
    check("full_value", 32'(last_out_val), 32'd255);

    // sync discards a partial block
    n0 = n_out;
    strobes(4, 8'd200);
    tick(1'b1, 1'b1, 8'd50, 1'b0);
    strobes(9, 8'd50);
    idle(20);
    check("sync_count", 32'(n_out - n0), 32'd1);
    check("sync_value", 32'(last_out_val), 32'd50);

    // overrun: second block lands mid-division
    n0 = n_out;
    strobes(20, 8'd10);
    idle(20);
    check("ovr_count", 32'(n_out - n0), 32'd1);
    check("ovr_value", 32'(last_out_val), 32'd10);
    check("ovr_set", 32'(overrun), 32'd1);
    tick(1'b0, 1'b0, '0, 1'b1);
    check("ovr_cleared", 32'(overrun), 32'd0);

    // back-to-back: second block completes in the result cycle
    n0 = n_out;
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
    idle(3);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
    idle(30);
    check("b2b_count", 32'(n_out - n0), 32'd2);
    check("b2b_spacing", 32'(last_out_cyc - prev_out_cyc), 32'd14);
    check("b2b_overrun", 32'(overrun), 32'd0);

    // reset five cycles after block completion
    strobes(10, 8'd33);
    idle(20);
    n0 = n_out;
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
    idle(4);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sample_out", 32'(sample_out), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    idle(3);
    reset_n = 1'b1;
    idle(20);
    check("mid_rst_no_output", 32'(n_out - n0), 32'd0);
    strobes(10, 8'd77);
    idle(20);
    check("post_rst_count", 32'(n_out - n0), 32'd1);
    check("post_rst_value", 32'(last_out_val), 32'd77);

    // randomized traffic with varying strobe density, syncs and clears
    for (int seg = 0; seg < 15; seg++) begin
      int dens;
      dens = $urandom_range(1, 6);
      for (int j = 0; j < 200; j++) begin
        tick(($urandom_range(0, dens - 1) == 0), ($urandom_range(0, 149) == 0),
             8'($urandom_range(0, 255)), ($urandom_range(0, 39) == 0));
      end
    end
    idle(30);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
